// File: rtl/uart_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types for the UART TX round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int NREQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    function automatic logic [NREQ-1:0] onehot(input idx_t i);
        logic [NREQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Request/TX handshake bundle between requesters, arbiter and
//               the UART TX core.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;

    logic [uart_arb_pkg::NREQ-1:0] req;
    logic                          tx_busy;
    uart_arb_pkg::idx_t            sel;
    logic [uart_arb_pkg::NREQ-1:0] grant;
    logic                          tx_start;
    logic [uart_arb_pkg::NREQ-1:0] done;
    logic                          err;

    modport master (
        input  req,
        input  tx_busy,
        output sel,
        output grant,
        output tx_start,
        output done,
        output err
    );

    modport slave (
        output req,
        output tx_busy,
        input  sel,
        input  grant,
        input  tx_start,
        input  done,
        input  err
    );

endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker; searches last+1 .. last.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  idx_t            last_i,
    output logic            valid_o,
    output idx_t            idx_o
);

    idx_t cand;

    // Walk from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = last_i;
        cand    = last_i;
        for (int k = NREQ; k >= 1; k--) begin
            cand = last_i + idx_t'(k);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART TX core among four
//               requesters. Optional busy timeout under ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
)
(
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  arb_io
);

    arb_state_e       state_q;
    idx_t             sel_q;
    idx_t             last_q;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  done_q;
    logic             tx_start_q;

    logic             w_pick_valid;
    idx_t             w_pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    logic [c_CNT_W-1:0] cnt_q;
    logic               err_q;
`endif

    uart_rr_pick u_pick (
        .req_i   (arb_io.req),
        .last_i  (last_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            last_q     <= idx_t'(NREQ - 1);
            grant_q    <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (w_pick_valid) begin
                        sel_q      <= w_pick_idx;
                        grant_q    <= onehot(w_pick_idx);
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    state_q <= WAIT_BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (arb_io.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    // The core never took the word: drop it but still advance the rotation.
                    else if (cnt_q == c_CNT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        last_q  <= sel_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!arb_io.tx_busy) begin
                        done_q  <= onehot(sel_q);
                        last_q  <= sel_q;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb_io.sel      = sel_q;
    assign arb_io.grant    = grant_q;
    assign arb_io.tx_start = tx_start_q;
    assign arb_io.done     = done_q;
`ifdef ARB_TIMEOUT_EN
    assign arb_io.err      = err_q;
`else
    assign arb_io.err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a simple
//               TX core model (busy 1 cycle after tx_start, 10 cycles long).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int TIMEOUT  = 16;
    localparam int BUSY_LEN = 10;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] req_tb = 4'b0000;
    logic       busy_m = 1'b0;
    logic       stuck  = 1'b0;

    int n_checks  = 0;
    int n_errors  = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    uart_tx_arbiter_if bus ();

    assign bus.req     = req_tb;
    assign bus.tx_busy = busy_m;

    uart_tx_arbiter #(.WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (bus)
    );

    always #5 clk = ~clk;

    // TX core model: busy rises one cycle after tx_start and lasts BUSY_LEN cycles.
    int   hold = 0;
    logic pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_m = 1'b0;
            hold   = 0;
            pend   = 1'b0;
        end else begin
            if (pend) begin
                busy_m = 1'b1;
                hold   = BUSY_LEN;
                pend   = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) busy_m = 1'b0;
            end
            if (bus.tx_start && !stuck) pend = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.tx_start)    start_cnt++;
            if (bus.done != '0)  done_cnt++;
            if (bus.err)         err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_start(input string tag, input int idx);
        int k = 0;
        do begin @(negedge clk); k++; end while (!bus.tx_start && k < 200);
        chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
        chk({tag, "_sel"},   32'(bus.sel),      32'(idx));
        chk({tag, "_grant"}, 32'(bus.grant),    32'(onehot(idx_t'(idx))));
    endtask

    task automatic expect_done(input string tag, input int idx);
        int k = 0;
        do begin @(negedge clk); k++; end while (bus.done == '0 && k < 200);
        chk({tag, "_done"},      32'(bus.done),  32'(onehot(idx_t'(idx))));
        chk({tag, "_grant_clr"}, 32'(bus.grant), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int s0, d0, k;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(bus.grant),    32'd0);
        chk("rst_sel",   32'(bus.sel),      32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_done",  32'(bus.done),     32'd0);
        chk("rst_err",   32'(bus.err),      32'd0);
        rst = 1'b0;

        // Single requester 0, 1-cycle grant latency, single start pulse
        @(negedge clk);
        req_tb = 4'b0001;
        @(negedge clk);
        chk("t1_grant", 32'(bus.grant),    32'h1);
        chk("t1_sel",   32'(bus.sel),      32'd0);
        chk("t1_start", 32'(bus.tx_start), 32'd1);
        req_tb = 4'b0000;
        @(negedge clk);
        chk("t1_start_pulse", 32'(bus.tx_start), 32'd0);
        chk("t1_grant_hold",  32'(bus.grant),    32'h1);
        expect_done("t1", 0);
        @(negedge clk);
        chk("t1_idle_done",  32'(bus.done),  32'd0);
        chk("t1_idle_grant", 32'(bus.grant), 32'd0);

        // All four requesting: 0,1,2,3,0,1,2,3
        do_reset();
        s0 = start_cnt;
        d0 = done_cnt;
        req_tb = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            expect_start($sformatf("t2_f%0d", f), f % 4);
            expect_done($sformatf("t2_f%0d", f), f % 4);
        end
        req_tb = 4'b0000;
        repeat (3) @(negedge clk);
        chk("t2_starts", 32'(start_cnt - s0), 32'd8);
        chk("t2_dones",  32'(done_cnt - d0),  32'd8);

        // last=1 then req=1001: 3 before 0
        req_tb = 4'b0010;
        expect_start("t3_a", 1);
        req_tb = 4'b0000;
        expect_done("t3_a", 1);
        req_tb = 4'b1001;
        expect_start("t3_b", 3);
        expect_done("t3_b", 3);
        expect_start("t3_c", 0);
        req_tb = 4'b0000;
        expect_done("t3_c", 0);

        // req changes during WAIT_DONE are ignored
        req_tb = 4'b0100;
        expect_start("t4_a", 2);
        repeat (4) @(negedge clk);
        req_tb = 4'b0001;
        @(negedge clk);
        chk("t4_grant_kept", 32'(bus.grant), 32'h4);
        expect_done("t4_a", 2);
        expect_start("t4_b", 0);
        req_tb = 4'b0000;
        expect_done("t4_b", 0);

        // Asynchronous reset in WAIT_DONE
        req_tb = 4'b0100;
        expect_start("t5_a", 2);
        req_tb = 4'b0000;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_grant", 32'(bus.grant),    32'd0);
        chk("t5_rst_sel",   32'(bus.sel),      32'd0);
        chk("t5_rst_done",  32'(bus.done),     32'd0);
        chk("t5_rst_start", 32'(bus.tx_start), 32'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        req_tb = 4'b0011;
        expect_start("t5_b", 0);
        expect_done("t5_b", 0);
        expect_start("t5_c", 1);
        req_tb = 4'b0000;
        expect_done("t5_c", 1);

`ifdef ARB_TIMEOUT_EN
        // Busy never rises: err after TIMEOUT cycles, rotation advances
        stuck  = 1'b1;
        req_tb = 4'b0101;
        expect_start("t6_a", 2);
        d0 = done_cnt;
        k  = 0;
        do begin @(negedge clk); k++; end while (!bus.err && k < 60);
        chk("t6_err_latency", 32'(k), 32'(TIMEOUT + 1));
        chk("t6_err_grant",   32'(bus.grant), 32'd0);
        chk("t6_err_done",    32'(bus.done),  32'd0);
        stuck = 1'b0;
        expect_start("t6_b", 0);
        req_tb = 4'b0000;
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        expect_done("t6_b", 0);
        @(negedge clk);
        chk("t6_err_count", 32'(err_cnt), 32'd1);
`else
        k = 0;
        repeat (3) @(negedge clk);
        chk("err_never", 32'(err_cnt + k), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
